// File: rtl/er_frame_sched_if.sv
// er_frame_sched_if: control, engine handshake and status signals of the frame scheduler
interface er_frame_sched_if;
  logic        run;
  logic        continuous;
  logic        frame_tick;
  logic        clr_start;
  logic        clr_done;
  logic        er_start;
  logic        er_done;
  logic        busy;
  logic [15:0] frames_drawn;
  logic [7:0]  overruns;
  logic        timeout;
  modport master (
    input  run, continuous, frame_tick, clr_done, er_done,
    output clr_start, er_start, busy, frames_drawn, overruns, timeout
  );
  modport slave (
    output run, continuous, frame_tick, clr_done, er_done,
    input  clr_start, er_start, busy, frames_drawn, overruns, timeout
  );
endinterface

// File: rtl/er_frame_sched.sv
// er_frame_sched: frame-synchronous clear-then-draw scheduler for the Earthrise engine
module er_frame_sched #(
  parameter int FRAME_DIV = 1,
  parameter bit CLEAR_EN  = 1'b1,
  parameter int WDOG_W    = 20
) (
  input logic              clk_sys,
  input logic              rst_sys,
  er_frame_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, CLEAR, CLR_WAIT, DRAW, ER_WAIT} state_t;
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  state_t state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0] overruns_q, overruns_d;
  logic timeout_q, timeout_d;
  logic clr_start_q, clr_start_d;
  logic er_start_q, er_start_d;
  logic busy_q, busy_d;
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    wdog_d     = wdog_q + 1'b1;
    frames_d   = frames_q;
    timeout_d  = timeout_q;
    overruns_d = (bus.frame_tick && busy_q && overruns_q != 8'hFF) ? overruns_q + 8'd1 : overruns_q;
    case (state_q)
      IDLE: if (bus.run) begin
        state_d    = ARM;
        div_d      = 8'd0;
        overruns_d = 8'd0;
        timeout_d  = 1'b0;
      end
      ARM: if (!bus.run) state_d = IDLE;
        else if (bus.frame_tick) begin
          div_d   = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
          state_d = (div_q != DIV_LAST) ? ARM : CLEAR_EN ? CLEAR : DRAW;
        end
      CLEAR: begin
        state_d = CLR_WAIT;
        wdog_d  = '0;
      end
      CLR_WAIT: if (bus.clr_done) state_d = DRAW;
        else if (wdog_q == '1) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      DRAW: begin
        state_d = ER_WAIT;
        wdog_d  = '0;
      end
      ER_WAIT: if (bus.er_done) begin
          frames_d = frames_q + 16'd1;
          state_d  = (bus.run && bus.continuous) ? ARM : IDLE;
        end else if (wdog_q == '1) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      default: state_d = IDLE;
    endcase
    clr_start_d = state_d == CLEAR;
    // er_start trails DRAW by a cycle, so it shows while the draw is already being waited on
    er_start_d  = state_q == DRAW;
    busy_d      = state_d inside {CLEAR, CLR_WAIT, DRAW, ER_WAIT};
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      wdog_q      <= '0;
      frames_q    <= 16'd0;
      overruns_q  <= 8'd0;
      timeout_q   <= 1'b0;
      clr_start_q <= 1'b0;
      er_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      wdog_q      <= wdog_d;
      frames_q    <= frames_d;
      overruns_q  <= overruns_d;
      timeout_q   <= timeout_d;
      clr_start_q <= clr_start_d;
      er_start_q  <= er_start_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.clr_start    = clr_start_q;
  assign bus.er_start     = er_start_q;
  assign bus.busy         = busy_q;
  assign bus.frames_drawn = frames_q;
  assign bus.overruns     = overruns_q;
  assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_er_frame_sched.sv
// tb_er_frame_sched: directed and randomized checks of er_frame_sched against a phase-level model
module tb_er_frame_sched;
  localparam int DIV_A  = 3;
  localparam int WMAX_A = (1 << 6) - 1;
  localparam int M_IDLE = 0, M_ARM = 1, M_CLR = 2, M_CWAIT = 3, M_DRAW = 4, M_EWAIT = 5;
  logic clk = 1'b0;
  logic rst;
  er_frame_sched_if bus_a ();
  er_frame_sched_if bus_b ();
  er_frame_sched #(.FRAME_DIV(DIV_A), .CLEAR_EN(1'b1), .WDOG_W(6)) dut_a (
    .clk_sys(clk), .rst_sys(rst), .bus(bus_a));
  er_frame_sched #(.FRAME_DIV(1), .CLEAR_EN(1'b0), .WDOG_W(4)) dut_b (
    .clk_sys(clk), .rst_sys(rst), .bus(bus_b));
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  int m_ph = M_IDLE, m_ticks = 0, m_wait = 0;
  bit e_clr, e_er, e_busy, e_to;
  logic [15:0] e_frames;
  int e_ovr;
  int c_cnt = -1, r_cnt = -1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_edge();
    int nph;
    if (rst) begin
      m_ph = M_IDLE; e_clr = 0; e_er = 0; e_busy = 0; e_to = 0; e_frames = 0; e_ovr = 0;
      return;
    end
    nph  = m_ph;
    e_er = (m_ph == M_DRAW);
    if (bus_a.frame_tick && m_ph >= M_CLR && e_ovr < 255) e_ovr++;
    case (m_ph)
      M_IDLE: if (bus_a.run) begin nph = M_ARM; m_ticks = 0; e_ovr = 0; e_to = 0; end
      M_ARM: if (!bus_a.run) nph = M_IDLE;
        else if (bus_a.frame_tick) begin
          m_ticks++;
          if (m_ticks % DIV_A == 0) nph = M_CLR;
        end
      M_CLR: begin nph = M_CWAIT; m_wait = 0; end
      M_CWAIT: begin
        if (bus_a.clr_done) nph = M_DRAW;
        else if (m_wait == WMAX_A) begin e_to = 1; nph = M_IDLE; end
        m_wait++;
      end
      M_DRAW: begin nph = M_EWAIT; m_wait = 0; end
      default: begin
        if (bus_a.er_done) begin
          e_frames++;
          nph = (bus_a.run && bus_a.continuous) ? M_ARM : M_IDLE;
        end else if (m_wait == WMAX_A) begin e_to = 1; nph = M_IDLE; end
        m_wait++;
      end
    endcase
    m_ph   = nph;
    e_clr  = (nph == M_CLR);
    e_busy = (nph >= M_CLR);
  endtask
  task automatic check_all();
    logic [27:0] obs, exp;
    obs = {bus_a.clr_start, bus_a.er_start, bus_a.busy, bus_a.timeout, bus_a.frames_drawn, bus_a.overruns};
    exp = {e_clr, e_er, e_busy, e_to, e_frames, 8'(e_ovr)};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL model_cmp t=%0t observed=%h expected=%h", $time, obs, exp);
    end
  endtask
  task automatic step();
    model_edge();
    @(negedge clk);
    {bus_a.frame_tick, bus_a.clr_done, bus_a.er_done} = '0;
    {bus_b.frame_tick, bus_b.clr_done, bus_b.er_done} = '0;
    check_all();
  endtask
  task automatic ticks3();
    for (int i = 0; i < 3; i++) begin
      bus_a.frame_tick = 1'b1;
      step();
      if (i < 2) step();
    end
  endtask
  task automatic wait_er(string tag);
    int n = 0;
    bit p = 0;
    while (!bus_a.er_start && n < 40) begin
      bus_a.clr_done = p;
      p = bus_a.clr_start;
      step();
      n++;
    end
    chk(tag, bus_a.er_start, 1);
  endtask
  task automatic respond(int lo, int hi);
    if (c_cnt == 0) bus_a.clr_done = 1'b1;
    if (c_cnt >= 0) c_cnt--;
    if (r_cnt == 0) bus_a.er_done = 1'b1;
    if (r_cnt >= 0) r_cnt--;
    if (e_clr) c_cnt = $urandom_range(hi, lo);
    if (e_er) r_cnt = $urandom_range(hi, lo);
  endtask
  initial begin
    int ers, extra, cs;
    bit p;
    rst = 1'b1;
    {bus_a.run, bus_a.continuous, bus_a.frame_tick, bus_a.clr_done, bus_a.er_done} = '0;
    {bus_b.run, bus_b.continuous, bus_b.frame_tick, bus_b.clr_done, bus_b.er_done} = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_outputs", {bus_a.clr_start, bus_a.er_start, bus_a.busy, bus_a.timeout,
                          bus_a.frames_drawn, bus_a.overruns}, 0);
    // single draw, clear done 5 cycles after clr_start, draw done 10 cycles after er_start
    bus_a.run = 1'b1;
    step();
    repeat (2) begin bus_a.frame_tick = 1'b1; step(); step(); end
    bus_a.frame_tick = 1'b1;
    step();
    chk("t1_clr_start", bus_a.clr_start, 1);
    chk("t1_busy", bus_a.busy, 1);
    repeat (5) step();
    chk("t1_clr_once", bus_a.clr_start, 0);
    bus_a.clr_done = 1'b1;
    step();
    chk("t1_er_early", bus_a.er_start, 0);
    step();
    chk("t1_er_lat", bus_a.er_start, 1);
    repeat (9) step();
    bus_a.er_done = 1'b1;
    step();
    chk("t1_frames", bus_a.frames_drawn, 1);
    chk("t1_idle", bus_a.busy, 0);
    // continuous with instant dones: draws only on every third tick
    bus_a.continuous = 1'b1;
    step();
    ers = 0;
    p = 0;
    for (int t = 1; t <= 9; t++) begin
      bus_a.frame_tick = 1'b1;
      step();
      repeat (6) begin
        bus_a.clr_done = p;
        p = bus_a.clr_start;
        bus_a.er_done = bus_a.er_start;
        if (bus_a.er_start) ers++;
        step();
      end
      chk($sformatf("t2_draws_after_tick%0d", t), ers, t / 3);
    end
    chk("t2_frames", bus_a.frames_drawn, 4);
    // ticks during ER_WAIT, the last one coincident with er_done
    ticks3();
    wait_er("t3_er_start");
    bus_a.frame_tick = 1'b1;
    step();
    step();
    bus_a.frame_tick = 1'b1;
    step();
    bus_a.frame_tick = 1'b1;
    bus_a.er_done = 1'b1;
    step();
    chk("t3_overruns", bus_a.overruns, 3);
    extra = 0;
    repeat (6) begin step(); extra += int'(bus_a.er_start); end
    chk("t3_no_extra_er", extra, 0);
    chk("t3_frames", bus_a.frames_drawn, 5);
    // watchdog expiry in ER_WAIT with run dropped; timeout survives until run rises
    ticks3();
    wait_er("t4_er_start");
    bus_a.run = 1'b0;
    repeat (WMAX_A) step();
    chk("t4_timeout_pre", bus_a.timeout, 0);
    chk("t4_busy_pre", bus_a.busy, 1);
    step();
    chk("t4_timeout", bus_a.timeout, 1);
    chk("t4_busy", bus_a.busy, 0);
    step();
    chk("t4_sticky", bus_a.timeout, 1);
    bus_a.run = 1'b1;
    step();
    chk("t4_cleared", bus_a.timeout, 0);
    // done arriving in the expiry cycle wins
    ticks3();
    wait_er("t4b_er_start");
    repeat (WMAX_A) step();
    bus_a.er_done = 1'b1;
    step();
    chk("t4b_no_timeout", bus_a.timeout, 0);
    chk("t4b_frames", bus_a.frames_drawn, 6);
    // run dropped in CLR_WAIT still completes the draw
    ticks3();
    step();
    bus_a.run = 1'b0;
    step();
    step();
    bus_a.clr_done = 1'b1;
    step();
    step();
    chk("t5_er_after_stop", bus_a.er_start, 1);
    bus_a.er_done = 1'b1;
    step();
    chk("t5_idle", bus_a.busy, 0);
    chk("t5_frames", bus_a.frames_drawn, 7);
    bus_a.run = 1'b1;
    step();
    bus_a.run = 1'b0;
    step();
    cs = 0;
    repeat (3) begin
      bus_a.frame_tick = 1'b1;
      step();
      cs += int'(bus_a.clr_start);
      step();
      cs += int'(bus_a.clr_start);
    end
    chk("t5_arm_abort", cs, 0);
    // reset in ER_WAIT, later er_done ignored
    bus_a.run = 1'b1;
    step();
    ticks3();
    wait_er("t6_er_start");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_outputs", {bus_a.clr_start, bus_a.er_start, bus_a.busy, bus_a.timeout,
                           bus_a.frames_drawn, bus_a.overruns}, 0);
    bus_a.er_done = 1'b1;
    step();
    chk("t6_frames", bus_a.frames_drawn, 0);
    chk("t6_busy", bus_a.busy, 0);
    // constant ticks across long draws drive overruns into saturation
    c_cnt = -1;
    r_cnt = -1;
    repeat (500) begin
      bus_a.frame_tick = 1'b1;
      respond(20, 20);
      step();
    end
    chk("sat_overruns", bus_a.overruns, 255);
    // randomized traffic, every cycle compared with the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(399, 0) == 0);
      respond(0, ($urandom_range(19, 0) == 0) ? 70 : 6);
      if ($urandom_range(99, 0) == 0) bus_a.clr_done = 1'b1;
      if ($urandom_range(99, 0) == 0) bus_a.er_done = 1'b1;
      bus_a.frame_tick = ($urandom_range(9, 0) == 0);
      if ($urandom_range(49, 0) == 0) bus_a.run = ~bus_a.run;
      if ($urandom_range(39, 0) == 0) bus_a.continuous = ~bus_a.continuous;
      step();
    end
    rst = 1'b0;
    // no-clear instance: tick to er_start in two cycles
    bus_b.run = 1'b1;
    step();
    bus_b.frame_tick = 1'b1;
    step();
    chk("b_er_early", bus_b.er_start, 0);
    chk("b_busy", bus_b.busy, 1);
    step();
    chk("b_er_lat", bus_b.er_start, 1);
    chk("b_no_clear", bus_b.clr_start, 0);
    bus_b.er_done = 1'b1;
    step();
    chk("b_frames", bus_b.frames_drawn, 1);
    chk("b_idle", bus_b.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
